// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and default sizing for the IF-stage fetch sequencer.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, SQUASH} state_t;
  localparam int SIZE_DEFAULT = 64;
  localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/fetch_ctrl_wait_counter.sv
// wait_counter: saturating wait counter with clear, increment and a sticky terminal flag.
module wait_counter #(
  parameter int W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_flag
);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  logic [W-1:0] r_count;
  logic r_flag;
  // flag sets on the same edge the count lands on the limit and only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_flag <= 1'b0;
    end else begin
      if (i_clr) r_count <= '0;
      else if (i_inc && r_count != LIM) r_count <= r_count + 1'b1;
      if (i_inc && !i_clr && r_count == LIM - 1'b1) r_flag <= 1'b1;
    end
  end
  assign o_flag = r_flag;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer handling imem req/ack, decode stalls and M-stage redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int size = SIZE_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken_M,
  input  logic [size-1:0] branch_target_M,
  input  logic            stall_D,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic            enable,
  output logic            PCSrc_F,
  output logic [size-1:0] PCBranch_F,
  output logic            inst_valid_F,
  output logic            flush_D,
  output logic            timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t r_state, w_next;
  logic [size-1:0] r_target;
  logic w_fetch, w_hold, w_squash, w_req, w_ack, w_br, w_go;
  // outputs are Mealy on ack so the PC loads on the ack edge itself
  always_comb begin
    w_fetch = r_state == FETCH;
    w_hold = r_state == HOLD;
    w_squash = r_state == SQUASH;
    w_req = w_fetch | w_squash;
    w_ack = w_req & imem_ack;
    w_br = branch_taken_M & (r_state != BOOT);
    w_go = w_br | !stall_D;
    imem_req = w_req;
    enable = (w_fetch & w_ack & w_go) | (w_squash & w_ack) | (w_hold & w_go);
    PCSrc_F = (w_fetch & w_ack & w_br) | (w_squash & w_ack) | (w_hold & w_br);
    flush_D = w_br;
    inst_valid_F = (w_fetch & w_ack & !w_br) | (w_hold & !w_br);
    PCBranch_F = (w_br & (w_ack | w_hold)) ? branch_target_M : r_target;
    w_next = r_state == BOOT ? FETCH :
             w_fetch ? (w_ack ? ((!w_br && stall_D) ? HOLD : FETCH) : (w_br ? SQUASH : FETCH)) :
             w_hold ? (w_go ? FETCH : HOLD) :
             (w_ack ? FETCH : SQUASH);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (w_br) r_target <= branch_target_M;
    end
  end
  wait_counter #(.W(CW), .LIMIT(TIMEOUT)) u_wait (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_ack),
    .i_inc (w_req & !imem_ack),
    .o_flag(timeout_err)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scenario tasks with inline checks plus a fetched-PC scoreboard for fetch_ctrl.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic branch_taken_M = 1'b0;
  logic [63:0] branch_target_M = '0;
  logic stall_D = 1'b0;
  logic imem_ack = 1'b0;
  logic imem_req, enable, PCSrc_F, inst_valid_F, flush_D, timeout_err;
  logic [63:0] PCBranch_F;
  logic [63:0] pc;
  logic [63:0] sb_exp;
  logic [4:0] ctl;
  logic [63:0] exp_q[$];
  int total = 0;
  int bad = 0;

  fetch_ctrl #(.size(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .branch_taken_M(branch_taken_M), .branch_target_M(branch_target_M),
    .stall_D(stall_D), .imem_ack(imem_ack), .imem_req(imem_req), .enable(enable), .PCSrc_F(PCSrc_F),
    .PCBranch_F(PCBranch_F), .inst_valid_F(inst_valid_F), .flush_D(flush_D), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  assign ctl = {imem_req, enable, PCSrc_F, flush_D, inst_valid_F};

  // fetch datapath PC register steered by the DUT
  always @(posedge clk or negedge reset)
    if (!reset) pc <= '0;
    else if (enable) pc <= PCSrc_F ? PCBranch_F : pc + 64'd4;

  // each accepted instruction must come from the next expected PC
  always @(negedge clk)
    if (reset && imem_req && imem_ack && inst_valid_F) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow pc=%0h", pc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (pc !== sb_exp) begin
          bad++;
          $display("FAIL sb_pc got=%0h exp=%0h", pc, sb_exp);
        end
      end
    end

  task automatic drive(input logic a, input logic b, input logic [63:0] t, input logic s);
    imem_ack = a;
    branch_taken_M = b;
    branch_target_M = t;
    stall_D = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({ctl, timeout_err, PCBranch_F} !== {6'b0, 64'h0}) begin
      bad++;
      $display("FAIL reset_outs got=%b/%0h exp=0", {ctl, timeout_err}, PCBranch_F);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 64'h40, 1'b0);
    total++;
    if (ctl !== 5'b00000) begin
      bad++;
      $display("FAIL boot_ctl got=%b exp=00000", ctl);
    end
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'(i * 4));
      drive(1'b1, 1'b0, '0, 1'b0);
      total++;
      if (ctl !== 5'b11001) begin
        bad++;
        $display("FAIL stream_ctl%0d got=%b exp=11001", i, ctl);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    exp_q.push_back(64'd16);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      total++;
      if (ctl !== 5'b10000) begin
        bad++;
        $display("FAIL lat_wait%0d got=%b exp=10000", i, ctl);
      end
      tick();
    end
    drive(1'b1, 1'b0, '0, 1'b0);
    total++;
    if (ctl !== 5'b11001) begin
      bad++;
      $display("FAIL lat_ack got=%b exp=11001", ctl);
    end
    tick();
  endtask

  task automatic test_stall();
    exp_q.push_back(64'd20);
    drive(1'b1, 1'b0, '0, 1'b1);
    total++;
    if (ctl !== 5'b10001) begin
      bad++;
      $display("FAIL stall_ack got=%b exp=10001", ctl);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (ctl !== 5'b00001) begin
        bad++;
        $display("FAIL hold%0d got=%b exp=00001", i, ctl);
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    total++;
    if (ctl !== 5'b01001) begin
      bad++;
      $display("FAIL hold_exit got=%b exp=01001", ctl);
    end
    tick();
    total++;
    if (pc !== 64'd24 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL stall_pc got=%0h/%b exp=18/1", pc, imem_req);
    end
  endtask

  task automatic test_squash();
    drive(1'b0, 1'b1, 64'h100, 1'b0);
    total++;
    if (ctl !== 5'b10010) begin
      bad++;
      $display("FAIL sq_flush got=%b exp=10010", ctl);
    end
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    total++;
    if (ctl !== 5'b10000 || PCBranch_F !== 64'h100) begin
      bad++;
      $display("FAIL sq_wait got=%b/%0h exp=10000/100", ctl, PCBranch_F);
    end
    tick();
    drive(1'b1, 1'b0, '0, 1'b0);
    total++;
    if (ctl !== 5'b11100 || PCBranch_F !== 64'h100) begin
      bad++;
      $display("FAIL sq_ack got=%b/%0h exp=11100/100", ctl, PCBranch_F);
    end
    tick();
    total++;
    if (pc !== 64'h100 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL sq_pc got=%0h/%b exp=100/1", pc, imem_req);
    end
    exp_q.push_back(64'h100);
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 64'h300, 1'b0);
    tick();
    drive(1'b0, 1'b1, 64'h380, 1'b0);
    total++;
    if (ctl !== 5'b10010) begin
      bad++;
      $display("FAIL sq_rebranch got=%b exp=10010", ctl);
    end
    tick();
    drive(1'b1, 1'b0, '0, 1'b0);
    total++;
    if (ctl !== 5'b11100 || PCBranch_F !== 64'h380) begin
      bad++;
      $display("FAIL sq_overwrite got=%b/%0h exp=11100/380", ctl, PCBranch_F);
    end
    tick();
    total++;
    if (pc !== 64'h380) begin
      bad++;
      $display("FAIL sq_pc2 got=%0h exp=380", pc);
    end
  endtask

  task automatic test_hold_branch();
    exp_q.push_back(64'h380);
    drive(1'b1, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 64'h200, 1'b1);
    total++;
    if (ctl !== 5'b01110 || PCBranch_F !== 64'h200) begin
      bad++;
      $display("FAIL hold_br got=%b/%0h exp=01110/200", ctl, PCBranch_F);
    end
    tick();
    total++;
    if (pc !== 64'h200 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL hold_br_pc got=%0h/%b exp=200/1", pc, imem_req);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      total++;
      if (ctl !== 5'b10000 || timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d got=%b/%b exp=10000/0", i, ctl, timeout_err);
      end
      tick();
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_set got=%b exp=1", timeout_err);
    end
    exp_q.push_back(64'h200);
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    total++;
    if (timeout_err !== 1'b1 || pc !== 64'h204) begin
      bad++;
      $display("FAIL to_sticky got=%b/%0h exp=1/204", timeout_err, pc);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({ctl, timeout_err, PCBranch_F} !== {6'b0, 64'h0}) begin
      bad++;
      $display("FAIL async_rst got=%b/%0h exp=0", {ctl, timeout_err}, PCBranch_F);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_squash();
    test_hold_branch();
    test_timeout();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
